// File: rtl/sos_stream_ctrl.sv
// Stream-side controller for one SOS biquad stage: input FIFO, one-in-flight issue with timeout,
// single-entry result register. Optional latency monitor (max_lat) enabled by SOS_CTRL_LATMON_EN.
module sos_stream_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 63
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [15:0]                     s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [15:0]                     m_data,
    output logic                            sos_valid_in,
    output logic [15:0]                     sos_data_in,
    input  logic                            sos_valid_out,
    input  logic [15:0]                     sos_data_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            busy,
    output logic                            timeout_err
`ifdef SOS_CTRL_LATMON_EN
    ,
    output logic [7:0]                      max_lat
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [CW-1:0]   wait_cnt;
    logic            push;
    logic            pop;

    // Status is a pure function of registered state: no path from m_ready or sos_valid_out.
    assign s_ready    = (count != LW'(FIFO_DEPTH));
    assign fifo_level = count;
    assign busy       = (state != IDLE);
    assign push       = s_valid && s_ready;
    assign pop        = (state == IDLE) && (count != '0) && !m_valid;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (pop) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            count <= LW'(count + LW'(push) - LW'(pop));
        end
    end

    // Issue FSM with registered stage and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sos_valid_in <= 1'b0;
            sos_data_in  <= '0;
            wait_cnt     <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            timeout_err  <= 1'b0;
`ifdef SOS_CTRL_LATMON_EN
            max_lat      <= '0;
`endif
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        sos_data_in  <= mem[rd_ptr];
                        sos_valid_in <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    sos_valid_in <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= CW'(wait_cnt + 1'b1);
                    // A result arriving on the timeout cycle still counts as a result.
                    if (sos_valid_out) begin
                        m_data  <= sos_data_out;
                        m_valid <= 1'b1;
                        state   <= IDLE;
`ifdef SOS_CTRL_LATMON_EN
                        if (wait_cnt > max_lat) begin
                            max_lat <= wait_cnt;
                        end
`endif
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sos_stream_ctrl.sv
// Self-checking bench for sos_stream_ctrl: directed scenarios plus a randomized run against
// an order-preserving reference model and a behavioural stage with programmable latency.
module tb_sos_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        sos_valid_in;
    logic [15:0] sos_data_in;
    logic        sos_valid_out;
    logic [15:0] sos_data_out;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        timeout_err;
`ifdef SOS_CTRL_LATMON_EN
    logic [7:0]  max_lat;
`endif

    logic        stage_vo = 1'b0;
    logic        spur_vo = 1'b0;
    logic [15:0] stage_do = 16'h0000;
    assign sos_valid_out = stage_vo | spur_vo;
    assign sos_data_out  = stage_do;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sent[$];
    int          issue_idx = 0;
    int          out_idx = 0;
    int          stage_lat = 7;
    bit          stage_rand = 1'b0;
    bit          resp_fixed = 1'b0;
    bit          rnd_mready = 1'b0;
    bit          pending = 1'b0;
    int          lat_cnt = 0;
    logic [15:0] held_in = 16'h0000;

    always #5 clk = ~clk;

    sos_stream_ctrl #(.FIFO_DEPTH(8), .TIMEOUT(63)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .sos_valid_in  (sos_valid_in),
        .sos_data_in   (sos_data_in),
        .sos_valid_out (sos_valid_out),
        .sos_data_out  (sos_data_out),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .timeout_err   (timeout_err)
`ifdef SOS_CTRL_LATMON_EN
        ,
        .max_lat       (max_lat)
`endif
    );

    // Reference stage transfer: a byte swap and XOR, or a fixed word for the single-sample case.
    function automatic logic [15:0] stage_fn(input logic [15:0] x);
        return resp_fixed ? 16'h1234 : ({x[7:0], x[15:8]} ^ 16'h5a5a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mready) m_ready = (($urandom % 4) != 0);
    endtask

    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 500) begin
            tick();
            n++;
        end
        if (!s_ready) chk("push_wait", 32'(s_ready), 32'd1);
        tick();
        sent.push_back(d);
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 200) begin
            tick();
            n++;
        end
        if (!m_valid) chk(tag, 32'(m_valid), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (out_idx < sent.size() && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_idx), 32'(sent.size()));
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_ready"},      32'(s_ready),      32'd1);
        chk({p, "_m_valid"},      32'(m_valid),      32'd0);
        chk({p, "_m_data"},       32'(m_data),       32'd0);
        chk({p, "_sos_valid_in"}, 32'(sos_valid_in), 32'd0);
        chk({p, "_sos_data_in"},  32'(sos_data_in),  32'd0);
        chk({p, "_fifo_level"},   32'(fifo_level),   32'd0);
        chk({p, "_busy"},         32'(busy),         32'd0);
        chk({p, "_timeout_err"},  32'(timeout_err),  32'd0);
    endtask

    // Behavioural stage: latches the issued sample, answers after a set number of cycles.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            stage_vo = 1'b0;
            if (pending) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    stage_vo = 1'b1;
                    stage_do = stage_fn(held_in);
                    pending  = 1'b0;
                end
            end
            if (rst_n && sos_valid_in) begin
                chk("one_in_flight", 32'(pending), 32'd0);
                if (issue_idx < sent.size()) chk("issue_order", 32'(sos_data_in), 32'(sent[issue_idx]));
                else chk("issue_extra", 32'(issue_idx), 32'(sent.size()));
                issue_idx++;
                held_in = sos_data_in;
                lat = stage_rand ? int'($urandom_range(1, 20)) : stage_lat;
                if (lat > 0) begin
                    pending = 1'b1;
                    lat_cnt = lat;
                end
            end
        end
    end

    // Result scoreboard: every downstream handshake must carry the next expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_valid && m_ready) begin
                if (out_idx < sent.size()) chk("result", 32'(m_data), 32'(stage_fn(sent[out_idx])));
                else chk("result_extra", 32'(out_idx), 32'(sent.size()));
                out_idx++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single sample with a fixed 7-cycle stage response.
        resp_fixed = 1'b1;
        push(16'h4000);
        chk("t1_pre_pulse", 32'(sos_valid_in), 32'd0);
        tick();
        chk("t1_pulse", 32'(sos_valid_in), 32'd1);
        chk("t1_pulse_data", 32'(sos_data_in), 32'h4000);
        tick();
        chk("t1_pulse_end", 32'(sos_valid_in), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (6) tick();
        chk("t1_mvalid_early", 32'(m_valid), 32'd0);
        tick();
        chk("t1_mvalid", 32'(m_valid), 32'd1);
        chk("t1_mdata", 32'(m_data), 32'h1234);
        tick();
        chk("t1_consumed", 32'(m_valid), 32'd0);
        chk("t1_issue_count", 32'(issue_idx), 32'd1);
        resp_fixed = 1'b0;

        // Spurious stage response while idle.
        spur_vo = 1'b1;
        tick();
        spur_vo = 1'b0;
        tick();
        chk("spur_mvalid", 32'(m_valid), 32'd0);
        chk("spur_err", 32'(timeout_err), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);

        // Burst to full behind a stalled result, then a 20-cycle downstream stall.
        m_ready = 1'b0;
        push(16'h00ff);
        wait_mvalid("burst_prime");
        for (int i = 1; i <= 8; i++) push(16'(i));
        chk("burst_ready_low", 32'(s_ready), 32'd0);
        chk("burst_level", 32'(fifo_level), 32'd8);
        held = stage_fn(16'h00ff);
        for (int i = 0; i < 20; i++) begin
            chk("stall_no_issue", 32'(sos_valid_in), 32'd0);
            chk("stall_mdata", 32'(m_data), 32'(held));
            tick();
        end
        m_ready = 1'b1;
        drain("burst_drained", 600);

        // Push and pop on the same edge at level 4.
        m_ready = 1'b0;
        push(16'h0abc);
        wait_mvalid("pp_prime");
        for (int i = 0; i < 4; i++) push(16'($urandom));
        chk("pp_level_pre", 32'(fifo_level), 32'd4);
        m_ready = 1'b1;
        tick();
        chk("pp_mvalid_clear", 32'(m_valid), 32'd0);
        s_valid = 1'b1;
        s_data  = 16'h7777;
        tick();
        sent.push_back(16'h7777);
        s_valid = 1'b0;
        chk("pp_level", 32'(fifo_level), 32'd4);
        chk("pp_issue", 32'(sos_valid_in), 32'd1);
        drain("pp_drained", 600);

        // Timeout on a silent stage; the queued sample must issue right after.
        stage_lat = 0;
        push(16'h1111);
        tick();
        chk("to_pulse", 32'(sos_valid_in), 32'd1);
        push(16'h2222);
        stage_lat = 5;
        repeat (63) tick();
        chk("to_err_early", 32'(timeout_err), 32'd0);
        chk("to_busy_early", 32'(busy), 32'd1);
        tick();
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_no_mvalid", 32'(m_valid), 32'd0);
        out_idx++;
        tick();
        chk("to_next_issue", 32'(sos_valid_in), 32'd1);
        chk("to_next_data", 32'(sos_data_in), 32'h2222);
        drain("to_drained", 200);

        // Randomized traffic, stage latency and downstream back-pressure.
        stage_rand = 1'b1;
        rnd_mready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            push(16'($urandom));
        end
        rnd_mready = 1'b0;
        m_ready    = 1'b1;
        drain("rand_drained", 3000);
        chk("rand_issue_count", 32'(issue_idx), 32'(sent.size()));
        stage_rand = 1'b0;

        // Reset while a sample is in flight with five queued.
        stage_lat = 20;
        for (int i = 0; i < 6; i++) push(16'(16'h0100 + i));
        chk("rw_level", 32'(fifo_level), 32'd5);
        chk("rw_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("rw");
        sent.delete();
        issue_idx = 0;
        out_idx   = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        chk("rw_stale_mvalid", 32'(m_valid), 32'd0);
        chk("rw_stale_err", 32'(timeout_err), 32'd0);
        chk("rw_stale_busy", 32'(busy), 32'd0);
        stage_lat = 4;
        push(16'h0bad);
        drain("rw_after", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sos_stream_ctrl.md
# sos_stream_ctrl

Stream-side controller for one SOS biquad stage. Accepts samples from an upstream valid/ready stream, buffers them in a small FIFO, and issues them to the stage one at a time as single-cycle `data_valid_in` pulses. It captures the stage's `data_valid_out`/`data_out` result and presents it on a downstream valid/ready stream. The stage cannot accept back-to-back samples because `w1`/`w2` update only when its result is produced, so this block enforces strict one-in-flight issue and supervises every issue with a timeout.

## Interface
- `FIFO_DEPTH`, 8: input FIFO entries; power of two, ≥2.
- `TIMEOUT`, 63: maximum cycles in WAIT before abandoning a sample; 1..255.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  upstream sample valid
- `s_ready`  out  1  upstream ready; equals FIFO not full
- `s_data`  in  16  upstream sample, Q1.15 signed
- `m_valid`  out  1  filtered result valid
- `m_ready`  in  1  downstream ready
- `m_data`  out  16  filtered result, Q1.15 signed
- `sos_valid_in`  out  1  to stage `data_valid_in`; one-cycle pulse
- `sos_data_in`  out  16  to stage `data_in`; held stable until the result returns
- `sos_valid_out`  in  1  from stage `data_valid_out`
- `sos_data_out`  in  16  from stage `data_out`
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `busy`  out  1  high in ISSUE or WAIT
- `timeout_err`  out  1  sticky; set on any timeout; cleared only by reset

## Operation
- FIFO: circular buffer with rd/wr pointers and count. Push on `s_valid && s_ready`. Pop only on transition IDLE→ISSUE. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave the count unchanged. `s_ready` is low when full, so no push occurs at full. No pop occurs at empty.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE→ISSUE when FIFO is non-empty and `m_valid`=0. On that edge: `sos_data_in`←FIFO head, pop, `sos_valid_in`←1.
  - ISSUE→WAIT unconditionally. On that edge: `sos_valid_in`←0, wait counter←0.
  - WAIT: counter increments each cycle.
    - If `sos_valid_out`=1: `m_data`←`sos_data_out`, `m_valid`←1, go to IDLE.
    - Else if counter==TIMEOUT: `timeout_err`←1, sample dropped, `m_valid` unchanged, go to IDLE.
    - If both occur in the same cycle, `sos_valid_out` wins.
- Output register: a single entry. `m_valid` clears on `m_valid && m_ready`. `m_data` holds while `m_valid`=1.
- `sos_valid_out` seen in IDLE or ISSUE is spurious: ignored and not captured, `timeout_err` unaffected.
- No arithmetic on data; samples pass through bit-exact.
- Reset (any time, including mid-WAIT): FIFO flushed, in-flight sample dropped, FSM→IDLE. The stage shares `rst_n`, so its state clears simultaneously.

## Timing
- Reset values: `s_ready`=1, `m_valid`=0, `m_data`=0, `sos_valid_in`=0, `sos_data_in`=0, `fifo_level`=0, `busy`=0, `timeout_err`=0.
- Sample pushed at edge N into an empty FIFO, FSM idle, `m_valid`=0: `sos_valid_in` is high during cycle N+1 → N+2.
- `m_valid` rises one edge after `sos_valid_out` is sampled in WAIT.
- Minimum issue-to-issue spacing: 3 + stage latency + 1 drain cycle (with `m_ready` held high).
- Timeout fires TIMEOUT+1 cycles after entering WAIT.
- `s_ready` and `fifo_level` are derived from the registered count; no combinational path from `m_ready` or `sos_valid_out`.

## Configuration
- `SOS_CTRL_LATMON_EN` defined:
  - Adds output `max_lat [7:0]`, reset 0.
  - On each accepted result, `max_lat` updates to max(`max_lat`, WAIT counter at capture).
  - Timeouts do not update it.
- Not defined: the port and logic are absent; all other behaviour is identical.

## Test plan
- Single sample: push 16'h4000 into an idle block, with a stage model responding 7 cycles after the pulse with 16'h1234 → exactly one `sos_valid_in` pulse carrying 16'h4000; `m_data`=16'h1234 with `m_valid` one cycle after the response.
- Burst of 8 samples 0x0001..0x0008, FIFO_DEPTH=8, stage latency 7 → `s_ready` drops after the 8th push; issues occur in order with no second pulse before each response; outputs appear in order.
- Downstream stall: hold `m_ready`=0 for 20 cycles with 3 samples queued → no further `sos_valid_in` while `m_valid`=1; `m_data` stable; draining resumes in order.
- Timeout: stage model never responds, TIMEOUT=63 → `timeout_err`=1 at 64 cycles after entering WAIT; next sample issued; `m_valid` never asserted for the dropped sample.
- Spurious `sos_valid_out` in IDLE → no capture, no error. Simultaneous push/pop at level 4 → level stays 4.
- Assert `rst_n` mid-WAIT with 5 entries queued → all outputs at reset values; the old response arriving after reset is ignored.
